// File: rtl/flags_ctrl.sv
// Flags register write controller: ALU/SETF flag updates, branch condition
// evaluation, and a small flag save stack for nested interrupt entry/return.
module flags_ctrl #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [2:0] op_class,
  input  logic [3:0] op_imm,
  input  logic [3:0] alu_flags,
  input  logic [3:0] cur_flags,
  input  logic [2:0] cond_code,
  input  logic       irq_enter,
  input  logic       irq_return,
  output logic       flags_en,
  output logic [3:0] flags_wdata,
  output logic       cond_true,
  output logic       busy,
  output logic [2:0] depth,
  output logic       ovf_err,
  output logic       unf_err,
  output logic       fsm_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_t;

  localparam int         IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] FULL = 3'(STACK_DEPTH);

  state_t     state_q, state_d;
  logic [2:0] depth_q, depth_d;
  logic [3:0] stack_q [STACK_DEPTH];
  logic [3:0] stack_d [STACK_DEPTH];
  logic       pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  logic       ret_req;
  logic       op_writes;
  logic [3:0] op_wdata;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  assign top_idx  = IW'(depth_q - 3'd1);
  assign push_idx = IW'(depth_q);

  // Instruction-driven flag update; LOGIC keeps V and C from the live register.
  always_comb begin
    op_writes = 1'b0;
    op_wdata  = 4'b0000;
    case (op_class)
      3'b001, 3'b011: begin
        op_writes = 1'b1;
        op_wdata  = alu_flags;
      end
      3'b010: begin
        op_writes = 1'b1;
        op_wdata  = {cur_flags[3:2], alu_flags[1:0]};
      end
      3'b100: begin
        op_writes = 1'b1;
        op_wdata  = op_imm;
      end
      default: begin
        op_writes = 1'b0;
        op_wdata  = 4'b0000;
      end
    endcase
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = cur_flags[0];
      3'b010: cond_true = ~cur_flags[0];
      3'b011: cond_true = cur_flags[1] ^ cur_flags[3];
      3'b100: cond_true = ~(cur_flags[1] ^ cur_flags[3]);
      3'b101: cond_true = cur_flags[2];
      3'b110: cond_true = ~cur_flags[2];
      default: cond_true = 1'b0;
    endcase
  end

  assign busy        = (state_q == RESTORE);
  assign fsm_state   = state_q;
  assign depth       = depth_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  // Gated by reset so an aborted restore never presents a write.
  assign flags_en    = ~reset & (busy | (op_valid & op_writes));
  assign flags_wdata = busy ? stack_q[top_idx] : op_wdata;

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    stack_d = stack_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ret_req = 1'b0;
    case (state_q)
      IDLE: begin
        ret_req = irq_return | pend_q;
        if (irq_enter) begin
          if (depth_q < FULL) begin
            stack_d[push_idx] = cur_flags;
            depth_d           = depth_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          // A return colliding with a push waits one IDLE cycle.
          pend_d = ret_req;
        end else if (ret_req) begin
          pend_d = 1'b0;
          if (depth_q != 3'd0) begin
            state_d = RESTORE;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      RESTORE: begin
        state_d = IDLE;
        depth_d = depth_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      depth_q <= 3'd0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= 4'b0000;
      end
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_flags_ctrl.sv
// Bench for flags_ctrl: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_flags_ctrl;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [2:0] op_class;
  logic [3:0] op_imm;
  logic [3:0] alu_flags;
  logic [3:0] cur_flags;
  logic [2:0] cond_code;
  logic       irq_enter;
  logic       irq_return;
  logic       flags_en;
  logic [3:0] flags_wdata;
  logic       cond_true;
  logic       busy;
  logic [2:0] depth;
  logic       ovf_err;
  logic       unf_err;
  logic       fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 0;

  flags_ctrl #(.STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_class(op_class),
    .op_imm(op_imm), .alu_flags(alu_flags), .cur_flags(cur_flags),
    .cond_code(cond_code), .irq_enter(irq_enter), .irq_return(irq_return),
    .flags_en(flags_en), .flags_wdata(flags_wdata), .cond_true(cond_true),
    .busy(busy), .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: saved flags as a LIFO queue.
  logic [3:0] m_stack[$];
  bit m_rest, m_pend, m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stack.delete();
      m_rest = 0; m_pend = 0; m_ovf = 0; m_unf = 0;
    end else if (m_rest) begin
      void'(m_stack.pop_back());
      m_rest = 0;
    end else begin
      bit ret;
      ret = irq_return || m_pend;
      if (irq_enter) begin
        if (m_stack.size() < SD) m_stack.push_back(cur_flags);
        else m_ovf = 1;
        m_pend = ret;
      end else if (ret) begin
        m_pend = 0;
        if (m_stack.size() > 0) m_rest = 1;
        else m_unf = 1;
      end
    end
  end

  function automatic bit m_cond(input logic [3:0] f, input logic [2:0] cc);
    bit z, n, c, v;
    z = f[0]; n = f[1]; c = f[2]; v = f[3];
    case (cc)
      3'd0: return 1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return n == v;
      3'd5: return c;
      3'd6: return !c;
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (model_on && !reset) begin
        bit e_en;
        logic [3:0] e_wd;
        e_en = 0;
        e_wd = 4'h0;
        if (m_rest) begin
          e_en = 1;
          e_wd = m_stack[m_stack.size() - 1];
        end else if (op_valid) begin
          case (op_class)
            3'd1, 3'd3: begin e_en = 1; e_wd = alu_flags; end
            3'd2: begin e_en = 1; e_wd = {cur_flags[3:2], alu_flags[1:0]}; end
            3'd4: begin e_en = 1; e_wd = op_imm; end
            default: e_en = 0;
          endcase
        end
        chk("m_flags_en", flags_en, e_en);
        if (e_en) chk("m_flags_wdata", flags_wdata, e_wd);
        chk("m_cond_true", cond_true, m_cond(cur_flags, cond_code));
        chk("m_busy", busy, m_rest);
        chk("m_depth", depth, m_stack.size());
        chk("m_ovf_err", ovf_err, m_ovf);
        chk("m_unf_err", unf_err, m_unf);
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] cls, input logic [3:0] imm,
                       input logic [3:0] alu, input logic [3:0] cur, input logic [2:0] cc,
                       input logic ent, input logic ret);
    @(negedge clk);
    op_valid = v; op_class = cls; op_imm = imm; alu_flags = alu;
    cur_flags = cur; cond_code = cc; irq_enter = ent; irq_return = ret;
  endtask

  task automatic idle();
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 0);
  endtask

  initial begin
    reset = 1;
    op_valid = 0; op_class = 0; op_imm = 0; alu_flags = 0;
    cur_flags = 0; cond_code = 0; irq_enter = 0; irq_return = 0;

    // Reset state, with a would-be write presented during reset.
    drive(1, 3'd1, 4'h0, 4'hA, 4'h0, 3'd0, 0, 0);
    #4;
    chk("rst_flags_en", flags_en, 0);
    chk("rst_depth", depth, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_unf", unf_err, 0);
    @(negedge clk);
    reset = 0;
    model_on = 1;

    // Flag update classes.
    drive(1, 3'd1, 4'h0, 4'b1010, 4'h0, 3'd0, 0, 0); #4;
    chk("arith_en", flags_en, 1);
    chk("arith_wd", flags_wdata, 4'b1010);
    drive(1, 3'd2, 4'h0, 4'b0011, 4'b1100, 3'd0, 0, 0); #4;
    chk("logic_wd", flags_wdata, 4'b1111);
    drive(1, 3'd4, 4'b0110, 4'h0, 4'h0, 3'd0, 0, 0); #4;
    chk("setf_wd", flags_wdata, 4'b0110);
    drive(1, 3'd3, 4'h0, 4'b0001, 4'hF, 3'd0, 0, 0); #4;
    chk("cmp_wd", flags_wdata, 4'b0001);
    drive(1, 3'd0, 4'h0, 4'hF, 4'h0, 3'd0, 0, 0); #4;
    chk("nop_en", flags_en, 0);
    drive(1, 3'd7, 4'hF, 4'hF, 4'h0, 3'd0, 0, 0); #4;
    chk("rsvd_en", flags_en, 0);
    drive(0, 3'd1, 4'h0, 4'hF, 4'h0, 3'd0, 0, 0); #4;
    chk("novalid_en", flags_en, 0);

    // Condition codes.
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0010, 3'd3, 0, 0); #4;
    chk("cc_lt_n", cond_true, 1);
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0010, 3'd4, 0, 0); #4;
    chk("cc_ge_n", cond_true, 0);
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0001, 3'd1, 0, 0); #4;
    chk("cc_eq_z", cond_true, 1);
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0001, 3'd2, 0, 0); #4;
    chk("cc_ne_z", cond_true, 0);
    foreach (m_stack[i]) ;
    for (int f = 0; f < 16; f += 3) begin
      for (int c = 0; c < 8; c++) begin
        drive(0, 3'd0, 4'h0, 4'h0, 4'(f), 3'(c), 0, 0);
      end
    end

    // Single save / restore.
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0101, 3'd0, 1, 0); #4;
    chk("sv_depth0", depth, 0);
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 1); #4;
    chk("sv_depth1", depth, 1);
    chk("sv_busy0", busy, 0);
    idle(); #4;
    chk("rs_busy", busy, 1);
    chk("rs_en", flags_en, 1);
    chk("rs_wd", flags_wdata, 4'b0101);
    idle(); #4;
    chk("rs_depth0", depth, 0);
    chk("rs_busy0", busy, 0);

    // Overflow, LIFO drain, underflow.
    for (int i = 0; i < 5; i++) drive(0, 3'd0, 4'h0, 4'h0, 4'(i + 1), 3'd0, 1, 0);
    idle(); #4;
    chk("ovf_depth", depth, 4);
    chk("ovf_err", ovf_err, 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 1);
      idle(); #4;
      chk("lifo_wd", flags_wdata, 8'(4 - k));
    end
    idle();
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 1); #4;
    chk("unf_en_same", flags_en, 0);
    idle(); #4;
    chk("unf_err", unf_err, 1);
    chk("unf_en", flags_en, 0);
    chk("unf_busy", busy, 0);

    // Enter and return in the same cycle: return deferred one cycle.
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0011, 3'd0, 1, 1);
    idle(); #4;
    chk("pend_busy0", busy, 0);
    chk("pend_depth", depth, 1);
    idle(); #4;
    chk("pend_busy1", busy, 1);
    chk("pend_wd", flags_wdata, 4'b0011);
    idle();

    // ALU update alongside return; op and enter ignored during restore.
    drive(0, 3'd0, 4'h0, 4'h0, 4'b1001, 3'd0, 1, 0);
    drive(1, 3'd1, 4'h0, 4'b0111, 4'h0, 3'd0, 0, 1); #4;
    chk("opret_wd", flags_wdata, 4'b0111);
    drive(1, 3'd1, 4'h0, 4'b0111, 4'h0, 3'd0, 1, 0); #4;
    chk("rsop_wd", flags_wdata, 4'b1001);
    chk("rsop_busy", busy, 1);
    idle(); #4;
    chk("rsent_depth", depth, 0);

    // ALU update alongside enter.
    drive(1, 3'd1, 4'h0, 4'b0101, 4'b1110, 3'd0, 1, 0); #4;
    chk("opent_wd", flags_wdata, 4'b0101);
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 1); #4;
    chk("opent_depth", depth, 1);
    idle(); #4;
    chk("opent_rs_wd", flags_wdata, 4'b1110);
    idle();

    // Reset pulsed in the middle of a restore.
    drive(0, 3'd0, 4'h0, 4'h0, 4'b0110, 3'd0, 1, 0);
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 1);
    drive(1, 3'd1, 4'h0, 4'hF, 4'h0, 3'd0, 0, 0);
    #1;
    chk("pre_rst_busy", busy, 1);
    #1;
    reset = 1;
    #2;
    chk("ar_busy", busy, 0);
    chk("ar_en", flags_en, 0);
    chk("ar_depth", depth, 0);
    chk("ar_ovf", ovf_err, 0);
    chk("ar_unf", unf_err, 0);
    @(negedge clk);
    reset = 0;
    idle(); #4;
    chk("ar_post_busy", busy, 0);
    chk("ar_post_depth", depth, 0);

    // Mixed traffic against the model.
    for (int n = 0; n < 200; n++) begin
      drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    idle();
    idle();
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
